// File: rtl/data_sram_arbiter.sv
// Round-robin arbiter sharing one single-port data SRAM between two masters,
// with optional per-master lock and a bounded lock hold time.
module data_sram_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [3:0]        m0_wen,
  input  logic [31:0]       m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [3:0]        m1_wen,
  input  logic [31:0]       m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_en,
  output logic [3:0]        s_wen,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              lock_err
);

  localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOCK0,
    LOCK1
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [1:0]       rd_pend_q, rd_pend_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             lock_err_q, lock_err_d;
  logic             gnt0, gnt1;

  // Upper byte-address bits lie outside the SRAM and are ignored.
  logic unused_addr;
  assign unused_addr = ^{m0_addr[31:ADDR_W], m1_addr[31:ADDR_W]};

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    lock_err_d = lock_err_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          gnt0 = last_q;
          gnt1 = !last_q;
        end else begin
          gnt0 = m0_req;
          gnt1 = m1_req;
        end
        if (gnt0 && m0_lock) begin
          state_d    = LOCK0;
          lock_cnt_d = '0;
        end else if (gnt1 && m1_lock) begin
          state_d    = LOCK1;
          lock_cnt_d = '0;
        end
      end
      LOCK0: begin
        gnt0 = m0_req;
        if (!m0_lock) begin
          state_d = IDLE;
        end else if (lock_cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          lock_err_d = 1'b1;
          last_d     = 1'b0;
        end else begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
      end
      LOCK1: begin
        gnt1 = m1_req;
        if (!m1_lock) begin
          state_d = IDLE;
        end else if (lock_cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          lock_err_d = 1'b1;
          last_d     = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // No grant may leave while reset is held low.
    if (!reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end
    rd_pend_d = {gnt1 && (m1_wen == 4'h0), gnt0 && (m0_wen == 4'h0)};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      rd_pend_q  <= 2'b00;
      lock_cnt_q <= '0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      rd_pend_q  <= rd_pend_d;
      lock_cnt_q <= lock_cnt_d;
      lock_err_q <= lock_err_d;
    end
  end

  always_comb begin
    s_wen   = 4'h0;
    s_addr  = '0;
    s_wdata = '0;
    unique case (1'b1)
      gnt0: begin
        s_wen   = m0_wen;
        s_addr  = m0_addr[ADDR_W-1:0];
        s_wdata = m0_wdata;
      end
      gnt1: begin
        s_wen   = m1_wen;
        s_addr  = m1_addr[ADDR_W-1:0];
        s_wdata = m1_wdata;
      end
      default: ;
    endcase
  end

  assign s_en      = gnt0 | gnt1;
  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rd_pend_q[0] & reset;
  assign m1_rvalid = rd_pend_q[1] & reset;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;
  assign lock_err  = lock_err_q;

endmodule

// File: doc/data_sram_arbiter.md
# data_sram_arbiter

Two-port round-robin arbiter that shares the single-port data SRAM between the CPU data path (master 0, behind the 1x2 bridge's SRAM leg) and a second requester such as a DMA or debug loader (master 1). It accepts at most one transfer per cycle, drives the SRAM enable/write-strobe/address/data lines, and routes the one-cycle-latency read data back to the issuing master with a valid pulse. An optional per-master lock keeps ownership across back-to-back transfers for read-modify-write sequences. A lock timeout counter bounds how long either master can hold the SRAM.

## Interface
Parameters:
- ADDR_W, 14, SRAM address width forwarded to the SRAM
- DATA_W, 32, data width
- LOCK_MAX, 16, maximum consecutive cycles a lock may be held before forced release (≥2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- m0_req / m1_req  in  1  transfer request; fields below valid while high
- m0_wen / m1_wen  in  4  byte write strobes; 0 = read
- m0_addr / m1_addr  in  32  byte address; bits [ADDR_W-1:0] forwarded
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_lock / m1_lock  in  1  request to keep ownership after this transfer
- m0_gnt / m1_gnt  out  1  transfer issued this cycle (combinational)
- m0_rvalid / m1_rvalid  out  1  read data valid (registered)
- m0_rdata / m1_rdata  out  DATA_W  both driven from s_rdata; qualified by rvalid
- s_en  out  1  SRAM enable
- s_wen  out  4  SRAM byte write enables
- s_addr  out  ADDR_W  SRAM address
- s_wdata  out  DATA_W  SRAM write data
- s_rdata  in  DATA_W  SRAM read data, valid one cycle after a read issue
- lock_err  out  1  sticky: a lock was force-released by timeout

## Operation
- States: IDLE, LOCK0, LOCK1. Registers: state, last (last granted master), rd_pend[1:0], lock_cnt, lock_err.
- IDLE: one requester → grant it. Both → grant master != last. last ← granted index on every grant.
- LOCKx: only master x is granted; other master's gnt = 0 regardless of req.
- Transition to LOCKx: from IDLE when master x is granted with mx_lock = 1.
- Stay in LOCKx while mx_lock = 1 and lock_cnt < LOCK_MAX-1. Leave to IDLE when mx_lock = 0 (in any cycle, with or without a transfer) or on timeout.
- Timeout: lock_cnt counts cycles spent in LOCKx (cleared on entry). When lock_cnt = LOCK_MAX-1, next state is IDLE, lock_err ← 1 (sticky until reset), last ← x so the other master wins the next tie.
- Mux: granted master's wen/addr[ADDR_W-1:0]/wdata drive s_*; s_en = m0_gnt | m1_gnt. No grant → s_en = 0, s_wen = 0, s_addr = 0, s_wdata = 0.
- Reads: grant with wen = 0 sets rd_pend[x] for one cycle; mx_rvalid = rd_pend[x]. Writes produce no rvalid; gnt is the write acknowledge.
- At most one of m0_gnt/m1_gnt high; at most one rvalid high.

## Timing
- Reset (reset = 0 at edge): state = IDLE, last = 1 (master 0 wins first tie), rd_pend = 0, lock_cnt = 0, lock_err = 0. Outputs: gnt = 0 while reset low, rvalid = 0, s_en = 0.
- Issue latency 0: req high in cycle N with arbitration won → gnt and s_en in cycle N.
- Read latency 1: read granted in cycle N → mx_rvalid and valid rdata in cycle N+1.
- Ungranted master must hold req and fields stable until gnt; arbiter holds no request copy.
- Back-to-back reads fully pipelined: one grant per cycle, rvalid per cycle.
- Reset asserted mid-operation: pending rvalid dropped, lock released, lock_err cleared in the next cycle.
- Lock deasserted in the same cycle as a granted transfer: transfer issues, state = IDLE next cycle.

## Test plan
- Single master: m0 writes 0xDEADBEEF to 0x10 (wen=0xF), then reads 0x10 → gnt same cycle each, m0_rvalid one cycle after the read, m0_rdata = 0xDEADBEEF, m1_rvalid stays 0.
- Contention: both req reads every cycle for 6 cycles after reset → grants alternate m0,m1,m0,m1,m0,m1; rvalid alternates one cycle later.
- Lock: m1 holds lock across 3 writes while m0 requests → m0_gnt = 0 for those 3 cycles; first cycle after m1_lock drops, m0 granted.
- Timeout: m0 holds lock and req for LOCK_MAX+4 cycles with m1 requesting → forced release after LOCK_MAX cycles in LOCK0, lock_err = 1, m1 granted next; lock_err stays 1 until reset.
- Reset mid-read: read granted in cycle N, reset low in cycle N+1 → no rvalid after reset, state IDLE, lock_err 0, first tie afterwards goes to m0.
- Idle bus: no req for 10 cycles → s_en = 0, s_wen = 0, s_addr = 0, s_wdata = 0, no rvalid.
